fetch_multi_inflight: RTL and testbench

- Next-generation instruction fetch front-end. Sits between the warp scheduler and the icache memory bus, and feeds the ibuffer.
- Allows up to INFLIGHT outstanding fetches per warp.
- Supports per-warp flush (branch redirect) using epoch tagging; stale icache responses are dropped internally.
- Enforces per-warp ibuffer credit so the ibuffer can never overflow, whatever the cache configuration.

---
 rtl/fetch_multi_inflight_if.sv | 63 ++++++
 rtl/fetch_multi_inflight.sv | 132 +++++++++++++
 tb/tb_fetch_multi_inflight.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_multi_inflight_if.sv
// fetch_multi_inflight_if: scheduler, flush, icache and ibuffer signals of the fetch front-end
interface fetch_multi_inflight_if #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int PC_BITS     = 31,
    parameter int ADDR_WIDTH  = 30,
    parameter int INSTR_WIDTH = 32,
    parameter int UUID_WIDTH  = 1,
    parameter int TAG_WIDTH   = 6
);
    localparam int NW_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    logic                   sched_valid;
    logic [NW_WIDTH-1:0]    sched_wid;
    logic [PC_BITS-1:0]     sched_PC;
    logic [NUM_THREADS-1:0] sched_tmask;
    logic [UUID_WIDTH-1:0]  sched_uuid;
    logic                   sched_ready;
    logic                   flush_valid;
    logic [NW_WIDTH-1:0]    flush_wid;
    logic                   icache_req_valid;
    logic [ADDR_WIDTH-1:0]  icache_req_addr;
    logic [TAG_WIDTH-1:0]   icache_req_tag;
    logic                   icache_req_ready;
    logic                   icache_rsp_valid;
    logic [INSTR_WIDTH-1:0] icache_rsp_data;
    logic [TAG_WIDTH-1:0]   icache_rsp_tag;
    logic                   icache_rsp_ready;
    logic                   fetch_valid;
    logic [NW_WIDTH-1:0]    fetch_wid;
    logic [PC_BITS-1:0]     fetch_PC;
    logic [NUM_THREADS-1:0] fetch_tmask;
    logic [INSTR_WIDTH-1:0] fetch_instr;
    logic [UUID_WIDTH-1:0]  fetch_uuid;
    logic                   fetch_ready;
    logic [NUM_WARPS-1:0]   ibuf_pop;
    logic                   busy;

    modport master (
        input  sched_valid, sched_wid, sched_PC, sched_tmask, sched_uuid,
        output sched_ready,
        input  flush_valid, flush_wid,
        output icache_req_valid, icache_req_addr, icache_req_tag,
        input  icache_req_ready,
        input  icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
        output icache_rsp_ready,
        output fetch_valid, fetch_wid, fetch_PC, fetch_tmask, fetch_instr, fetch_uuid,
        input  fetch_ready, ibuf_pop,
        output busy
    );

    modport slave (
        output sched_valid, sched_wid, sched_PC, sched_tmask, sched_uuid,
        input  sched_ready,
        output flush_valid, flush_wid,
        input  icache_req_valid, icache_req_addr, icache_req_tag,
        output icache_req_ready,
        output icache_rsp_valid, icache_rsp_data, icache_rsp_tag,
        input  icache_rsp_ready,
        input  fetch_valid, fetch_wid, fetch_PC, fetch_tmask, fetch_instr, fetch_uuid,
        output fetch_ready, ibuf_pop,
        input  busy
    );
endinterface

// File: rtl/fetch_multi_inflight.sv
// fetch_multi_inflight: multi-outstanding instruction fetch with per-warp epoch flush and ibuffer credit
module fetch_multi_inflight #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int PC_BITS     = 31,
    parameter int ADDR_WIDTH  = 30,
    parameter int INSTR_WIDTH = 32,
    parameter int UUID_WIDTH  = 1,
    parameter int INFLIGHT    = 2,
    parameter int IBUF_SIZE   = 4,
    parameter int EPOCH_BITS  = 2,
    localparam int NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int SW         = (INFLIGHT > 1) ? $clog2(INFLIGHT) : 1,
    localparam int TAG_WIDTH  = UUID_WIDTH + EPOCH_BITS + SW + NW_WIDTH
) (
    input logic clk,
    input logic reset,
    fetch_multi_inflight_if.master bus
);
    localparam int IW = $clog2(INFLIGHT + 1);
    localparam int CW = $clog2(IBUF_SIZE + 1);
    localparam int RW = ADDR_WIDTH + TAG_WIDTH;

    logic [SW-1:0]          wr_slot     [NUM_WARPS];
    logic [SW-1:0]          rd_slot     [NUM_WARPS];
    logic [IW-1:0]          inflight    [NUM_WARPS];
    logic [IW-1:0]          inflight_nx [NUM_WARPS];
    logic [CW-1:0]          credit      [NUM_WARPS];
    logic [CW-1:0]          credit_nx   [NUM_WARPS];
    logic [EPOCH_BITS-1:0]  epoch       [NUM_WARPS];
    logic [PC_BITS-1:0]     pc_mem      [NUM_WARPS][INFLIGHT];
    logic [NUM_THREADS-1:0] tmask_mem   [NUM_WARPS][INFLIGHT];
    logic [EPOCH_BITS-1:0]  ep_mem      [NUM_WARPS][INFLIGHT];
    logic                   live_q, ob_valid, sk_valid, busy_q;
    logic [RW-1:0]          ob_data, sk_data, req_in;
    logic                   fire, rsp_live, rsp_fire, epoch_clash, pop_underflow, any_busy;
    logic [EPOCH_BITS-1:0]  req_epoch, rsp_epoch;
    logic [NW_WIDTH-1:0]    rsp_wid;
    logic [SW-1:0]          rsp_slot;

    assign bus.sched_ready = live_q && !sk_valid && inflight[bus.sched_wid] < IW'(INFLIGHT)
                             && credit[bus.sched_wid] < CW'(IBUF_SIZE);
    assign fire      = bus.sched_valid && bus.sched_ready;
    // a flush landing with the request must tag it with the post-flush epoch
    assign req_epoch = epoch[bus.sched_wid] + EPOCH_BITS'(bus.flush_valid && bus.flush_wid == bus.sched_wid);
    assign req_in    = {bus.sched_PC[1 +: ADDR_WIDTH], bus.sched_uuid, req_epoch, wr_slot[bus.sched_wid], bus.sched_wid};
    assign bus.icache_req_valid = ob_valid;
    assign {bus.icache_req_addr, bus.icache_req_tag} = ob_data;

    assign rsp_wid   = bus.icache_rsp_tag[0 +: NW_WIDTH];
    assign rsp_slot  = bus.icache_rsp_tag[NW_WIDTH +: SW];
    assign rsp_epoch = bus.icache_rsp_tag[NW_WIDTH + SW +: EPOCH_BITS];
    assign rsp_live  = rsp_epoch == epoch[rsp_wid];
    assign rsp_fire  = bus.icache_rsp_valid && bus.icache_rsp_ready;
    assign bus.icache_rsp_ready = rsp_live ? bus.fetch_ready : 1'b1;
    assign bus.fetch_valid = bus.icache_rsp_valid && rsp_live;
    assign bus.fetch_wid   = rsp_wid;
    assign bus.fetch_PC    = pc_mem[rsp_wid][rsp_slot];
    assign bus.fetch_tmask = tmask_mem[rsp_wid][rsp_slot];
    assign bus.fetch_instr = bus.icache_rsp_data;
    assign bus.fetch_uuid  = bus.icache_rsp_tag[TAG_WIDTH-1 -: UUID_WIDTH];
    assign bus.busy        = busy_q;

    always_comb begin
        any_busy      = 1'b0;
        pop_underflow = 1'b0;
        epoch_clash   = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            inflight_nx[w] = inflight[w] + IW'(fire && bus.sched_wid == NW_WIDTH'(w))
                             - IW'(rsp_fire && rsp_wid == NW_WIDTH'(w));
            credit_nx[w]   = credit[w] + CW'(fire && bus.sched_wid == NW_WIDTH'(w))
                             - CW'(rsp_fire && !rsp_live && rsp_wid == NW_WIDTH'(w)) - CW'(bus.ibuf_pop[w]);
            any_busy      |= inflight_nx[w] != '0;
            pop_underflow |= bus.ibuf_pop[w] && credit[w] == '0;
        end
        // slots from rd_slot onward, inflight of them, are still owed a response
        for (int s = 0; s < INFLIGHT; s++)
            epoch_clash |= (IW'(SW'(SW'(s) - rd_slot[bus.flush_wid])) < inflight[bus.flush_wid])
                           && (ep_mem[bus.flush_wid][s] == epoch[bus.flush_wid] + 1'b1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_q   <= 1'b0;
            ob_valid <= 1'b0;
            sk_valid <= 1'b0;
            busy_q   <= 1'b0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                wr_slot[w]  <= '0;
                rd_slot[w]  <= '0;
                inflight[w] <= '0;
                credit[w]   <= '0;
                epoch[w]    <= '0;
            end
        end else begin
            live_q <= 1'b1;
            busy_q <= any_busy;
            if (!ob_valid || bus.icache_req_ready) begin
                ob_valid <= sk_valid || fire;
                ob_data  <= sk_valid ? sk_data : req_in;
                sk_valid <= 1'b0;
            end else if (fire) begin
                sk_valid <= 1'b1;
                sk_data  <= req_in;
            end
            for (int w = 0; w < NUM_WARPS; w++) begin
                inflight[w] <= inflight_nx[w];
                credit[w]   <= credit_nx[w];
                if (fire && bus.sched_wid == NW_WIDTH'(w))
                    wr_slot[w] <= wr_slot[w] + SW'(INFLIGHT > 1);
                if (rsp_fire && rsp_wid == NW_WIDTH'(w))
                    rd_slot[w] <= rd_slot[w] + SW'(INFLIGHT > 1);
                if (bus.flush_valid && bus.flush_wid == NW_WIDTH'(w))
                    epoch[w] <= epoch[w] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            pc_mem[bus.sched_wid][wr_slot[bus.sched_wid]]    <= bus.sched_PC;
            tmask_mem[bus.sched_wid][wr_slot[bus.sched_wid]] <= bus.sched_tmask;
            ep_mem[bus.sched_wid][wr_slot[bus.sched_wid]]    <= req_epoch;
        end
    end

    a_pc_nonzero: assert property (@(posedge clk) disable iff (!reset) bus.sched_valid |-> bus.sched_PC != '0);
    a_pop_credit: assert property (@(posedge clk) disable iff (!reset) !pop_underflow);
    a_epoch_wrap: assert property (@(posedge clk) disable iff (!reset) bus.flush_valid |-> !epoch_clash);
    a_rsp_order:  assert property (@(posedge clk) disable iff (!reset)
                                   rsp_fire |-> inflight[rsp_wid] != '0 && rsp_slot == rd_slot[rsp_wid]);
endmodule

// File: tb/tb_fetch_multi_inflight.sv
// tb_fetch_multi_inflight: directed vector table plus corner-case sequences for fetch_multi_inflight
module tb_fetch_multi_inflight;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [35:0] req_q [$];

    typedef struct {
        int          wid;
        logic [30:0] pc;
        logic [3:0]  tm;
        logic        uuid;
        logic [31:0] instr;
        logic [29:0] addr;
        logic [5:0]  tag;
    } vec_t;
    vec_t vecs [5];

    fetch_multi_inflight_if ifc ();
    fetch_multi_inflight dut (.clk(clk), .reset(reset), .bus(ifc));

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ifc.icache_req_valid && ifc.icache_req_ready)
            req_q.push_back({ifc.icache_req_addr, ifc.icache_req_tag});

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_req(input int w, input logic [30:0] pc, input logic [3:0] tm, input logic u,
                            input int budget, output int n);
        ifc.sched_valid = 1'b1;
        ifc.sched_wid   = 2'(w);
        ifc.sched_PC    = pc;
        ifc.sched_tmask = tm;
        ifc.sched_uuid  = u;
        n = -1;
        for (int i = 0; i < budget && n < 0; i++) begin
            #1;
            if (ifc.sched_ready) n = i;
            @(negedge clk);
        end
        ifc.sched_valid = 1'b0;
    endtask

    task automatic wait_req(output logic [29:0] a, output logic [5:0] t);
        int i = 0;
        while (req_q.size() == 0 && i < 10) begin
            @(negedge clk);
            i++;
        end
        if (req_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL req_timeout: no icache request within 10 cycles");
            a = '0;
            t = '0;
        end else
            {a, t} = req_q.pop_front();
    endtask

    task automatic send_rsp(input string nm, input logic [5:0] t, input logic [31:0] d, input logic live,
                            input logic [30:0] pc, input logic [3:0] tm, input logic u, input int w);
        ifc.icache_rsp_valid = 1'b1;
        ifc.icache_rsp_tag   = t;
        ifc.icache_rsp_data  = d;
        #1;
        check({nm, "_fetch_valid"}, ifc.fetch_valid, live);
        check({nm, "_rsp_ready"}, ifc.icache_rsp_ready, 1);
        if (live) begin
            check({nm, "_pc"}, ifc.fetch_PC, pc);
            check({nm, "_tmask"}, ifc.fetch_tmask, tm);
            check({nm, "_instr"}, ifc.fetch_instr, d);
            check({nm, "_uuid"}, ifc.fetch_uuid, u);
            check({nm, "_wid"}, ifc.fetch_wid, w);
        end
        @(negedge clk);
        ifc.icache_rsp_valid = 1'b0;
    endtask

    task automatic pop(input int w, input int cnt);
        ifc.ibuf_pop = 4'(1 << w);
        repeat (cnt) @(negedge clk);
        ifc.ibuf_pop = '0;
    endtask

    initial begin
        int          n;
        logic [29:0] a, a2;
        logic [5:0]  t, t2, t3;
        vecs[0] = '{0, 31'h40,       4'b1111, 1'b0, 32'h00000013, 30'h20,       6'h00};
        vecs[1] = '{1, 31'h1000,     4'b0101, 1'b1, 32'hDEADBEEF, 30'h800,      6'h21};
        vecs[2] = '{3, 31'h7FFFFFFE, 4'b1000, 1'b0, 32'hFFFFFFFF, 30'h3FFFFFFF, 6'h03};
        vecs[3] = '{2, 31'h2,        4'b0001, 1'b1, 32'h00000001, 30'h1,        6'h22};
        vecs[4] = '{0, 31'h46,       4'b0011, 1'b1, 32'h12345678, 30'h23,       6'h24};
        ifc.sched_valid = 0; ifc.sched_wid = 0; ifc.sched_PC = 0; ifc.sched_tmask = 0; ifc.sched_uuid = 0;
        ifc.flush_valid = 0; ifc.flush_wid = 0; ifc.icache_req_ready = 1;
        ifc.icache_rsp_valid = 0; ifc.icache_rsp_data = 0; ifc.icache_rsp_tag = 0;
        ifc.fetch_ready = 1; ifc.ibuf_pop = 0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", ifc.icache_req_valid, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_sched_ready", ifc.sched_ready, 0);
        check("rst_fetch_valid", ifc.fetch_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_sched_ready", ifc.sched_ready, 1);
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            send_req(vecs[k].wid, vecs[k].pc, vecs[k].tm, vecs[k].uuid, 4, n);
            check($sformatf("v%0d_accept", k), n >= 0, 1);
            wait_req(a, t);
            check($sformatf("v%0d_addr", k), a, vecs[k].addr);
            check($sformatf("v%0d_tag", k), t, vecs[k].tag);
            check($sformatf("v%0d_busy_hi", k), ifc.busy, 1);
            send_rsp($sformatf("v%0d", k), t, vecs[k].instr, 1'b1, vecs[k].pc, vecs[k].tm, vecs[k].uuid, vecs[k].wid);
            check($sformatf("v%0d_busy_lo", k), ifc.busy, 0);
            pop(vecs[k].wid, 1);
        end

        // inflight limit on warp 1
        send_req(1, 31'h100, 4'b1111, 0, 4, n);
        check("inf_a_accept", n >= 0, 1);
        send_req(1, 31'h104, 4'b1111, 0, 4, n);
        check("inf_b_accept", n == 0, 1);
        send_req(1, 31'h108, 4'b1111, 0, 3, n);
        check("inf_c_stall", n < 0, 1);
        wait_req(a, t);
        wait_req(a2, t2);
        check("inf_a_addr", a, 30'h80);
        check("inf_b_addr", a2, 30'h82);
        send_rsp("inf_a", t, 32'hA, 1'b1, 31'h100, 4'b1111, 0, 1);
        send_req(1, 31'h108, 4'b1111, 0, 1, n);
        check("inf_c_resume", n == 0, 1);
        wait_req(a, t3);
        send_rsp("inf_b", t2, 32'hB, 1'b1, 31'h104, 4'b1111, 0, 1);
        send_rsp("inf_c", t3, 32'hC, 1'b1, 31'h108, 4'b1111, 0, 1);
        pop(1, 3);

        // credit limit on warp 3
        for (int i = 0; i < 4; i++) begin
            send_req(3, 31'h500 + 31'(4 * i), 4'b0110, 0, 4, n);
            check($sformatf("cr%0d_accept", i), n >= 0, 1);
            wait_req(a, t);
            send_rsp($sformatf("cr%0d", i), t, 32'h500 + 32'(i), 1'b1, 31'h500 + 31'(4 * i), 4'b0110, 0, 3);
        end
        send_req(3, 31'h510, 4'b0110, 0, 3, n);
        check("cr_block", n < 0, 1);
        pop(3, 1);
        send_req(3, 31'h510, 4'b0110, 0, 1, n);
        check("cr_resume", n == 0, 1);
        wait_req(a, t);
        send_rsp("cr4", t, 32'h510, 1'b1, 31'h510, 4'b0110, 0, 3);
        pop(3, 4);

        // flush with two outstanding on warp 2
        send_req(2, 31'h200, 4'b1111, 0, 4, n);
        send_req(2, 31'h204, 4'b1111, 0, 4, n);
        wait_req(a, t);
        wait_req(a2, t2);
        ifc.flush_valid = 1'b1;
        ifc.flush_wid   = 2'd2;
        @(negedge clk);
        ifc.flush_valid = 1'b0;
        send_rsp("stale0", t, 32'hBAD0, 1'b0, 0, 0, 0, 2);
        send_rsp("stale1", t2, 32'hBAD1, 1'b0, 0, 0, 0, 2);
        check("stale_busy", ifc.busy, 0);
        for (int i = 0; i < 4; i++) begin
            send_req(2, 31'h80 + 31'(4 * i), 4'b0011, 1, 4, n);
            check($sformatf("fl%0d_accept", i), n >= 0, 1);
            wait_req(a, t);
            check($sformatf("fl%0d_epoch", i), t[4:3], 1);
            send_rsp($sformatf("fl%0d", i), t, 32'h80 + 32'(i), 1'b1, 31'h80 + 31'(4 * i), 4'b0011, 1, 2);
        end
        send_req(2, 31'h90, 4'b0011, 1, 3, n);
        check("fl_credit_block", n < 0, 1);
        pop(2, 4);

        // same-cycle flush and request on warp 0
        ifc.flush_valid = 1'b1;
        ifc.flush_wid   = 2'd0;
        send_req(0, 31'h300, 4'b1010, 0, 1, n);
        ifc.flush_valid = 1'b0;
        check("sf_accept", n == 0, 1);
        wait_req(a, t);
        check("sf_tag", t, 6'h08);
        send_rsp("sf", t, 32'h300, 1'b1, 31'h300, 4'b1010, 0, 0);
        pop(0, 1);

        // asynchronous reset with two requests buffered
        ifc.icache_req_ready = 1'b0;
        send_req(1, 31'h400, 4'b1111, 0, 4, n);
        send_req(1, 31'h404, 4'b1111, 0, 4, n);
        #1;
        check("ar_buffered", ifc.icache_req_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_req_valid", ifc.icache_req_valid, 0);
        check("ar_busy", ifc.busy, 0);
        check("ar_sched_ready", ifc.sched_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        ifc.icache_req_ready = 1'b1;
        req_q.delete();
        @(negedge clk);
        send_req(1, 31'h40, 4'b1111, 0, 4, n);
        check("ar_accept", n >= 0, 1);
        wait_req(a, t);
        check("ar_addr", a, 30'h20);
        check("ar_tag", t, 6'h01);
        send_rsp("ar", t, 32'h13, 1'b1, 31'h40, 4'b1111, 0, 1);
        check("ar_busy_lo", ifc.busy, 0);
        pop(1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
